// File: rtl/atm_account_server.sv
// Account store and authorizer for the ATM front end.
// It holds the PIN, balance, failed-try counter and lock flag for each card.
// Requests are served one at a time: IDLE accepts a request, EXEC evaluates
// and commits it, and RESP holds the registered response until it is taken.
module atm_account_server #(
  parameter int          NUM_ACCOUNTS  = 4,
  parameter logic [15:0] INIT_PIN      = 16'h1234,
  parameter logic [15:0] INIT_BALANCE  = 16'h0500,
  parameter int          MAX_PIN_TRIES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [7:0]              req_card,
  input  logic [15:0]             req_pin,
  input  logic [15:0]             req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [7:0]              rsp_status,
  output logic [15:0]             rsp_balance,
  output logic [NUM_ACCOUNTS-1:0] locked
);

  localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);

  localparam logic [2:0] OP_VERIFY     = 3'd0;
  localparam logic [2:0] OP_BALANCE    = 3'd1;
  localparam logic [2:0] OP_WITHDRAW   = 3'd2;
  localparam logic [2:0] OP_DEPOSIT    = 3'd3;
  localparam logic [2:0] OP_PIN_CHANGE = 3'd4;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_CARD = 8'h01;
  localparam logic [7:0] ST_BAD_PIN  = 8'h02;
  localparam logic [7:0] ST_LOCKED   = 8'h03;
  localparam logic [7:0] ST_NO_FUNDS = 8'h04;
  localparam logic [7:0] ST_OVERFLOW = 8'h05;
  localparam logic [7:0] ST_BAD_OP   = 8'h06;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t state_q, state_d;

  // Per-account storage
  logic [15:0]             pin_q   [NUM_ACCOUNTS];
  logic [15:0]             bal_q   [NUM_ACCOUNTS];
  logic [TRY_W-1:0]        tries_q [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] locked_q;

  // Request captured at acceptance
  logic [2:0]  op_q;
  logic [7:0]  card_q;
  logic [15:0] pin_in_q;
  logic [15:0] data_q;

  // Registered response
  logic [7:0]  rsp_status_q;
  logic [15:0] rsp_bal_q;

  // Evaluation results for the request being executed
  logic [15:0]      cur_pin, cur_bal;
  logic [TRY_W-1:0] cur_tries;
  logic             cur_lock;
  logic [16:0]      sum17;
  logic [7:0]       status_d;
  logic [15:0]      rsp_bal_d;
  logic [15:0]      pin_d, bal_d;
  logic [TRY_W-1:0] tries_d;
  logic             lock_d;
  logic             wr_d;

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_status  = rsp_status_q;
  assign rsp_balance = rsp_bal_q;
  assign locked      = locked_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: one request in flight, response held until taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture request fields only on the accepting edge
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      op_q     <= req_op;
      card_q   <= req_card;
      pin_in_q <= req_pin;
      data_q   <= req_data;
    end
  end

  // Select the addressed account; out-of-range cards read as zero and are
  // rejected before any of these values matter
  always_comb begin
    cur_pin   = '0;
    cur_bal   = '0;
    cur_tries = '0;
    cur_lock  = 1'b0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (card_q == 8'(i)) begin
        cur_pin   = pin_q[i];
        cur_bal   = bal_q[i];
        cur_tries = tries_q[i];
        cur_lock  = locked_q[i];
      end
    end
  end

  // Authorize and compute the outcome; checks are in priority order
  always_comb begin
    sum17     = {1'b0, cur_bal} + {1'b0, data_q};
    status_d  = ST_OK;
    rsp_bal_d = 16'h0000;
    pin_d     = cur_pin;
    bal_d     = cur_bal;
    tries_d   = cur_tries;
    lock_d    = cur_lock;
    wr_d      = 1'b0;
    if (int'(card_q) >= NUM_ACCOUNTS) begin
      status_d = ST_BAD_CARD;
    end else if (op_q > OP_PIN_CHANGE) begin
      status_d = ST_BAD_OP;
    end else if (cur_lock) begin
      status_d = ST_LOCKED;
    end else if (pin_in_q != cur_pin) begin
      status_d = ST_BAD_PIN;
      wr_d     = 1'b1;
      tries_d  = cur_tries + 1'b1;
      if (tries_d == TRY_W'(MAX_PIN_TRIES)) lock_d = 1'b1;
    end else begin
      // Correct PIN: the consecutive-failure count restarts
      wr_d      = 1'b1;
      tries_d   = '0;
      rsp_bal_d = cur_bal;
      unique case (op_q)
        OP_WITHDRAW: begin
          if (data_q > cur_bal) begin
            status_d = ST_NO_FUNDS;
          end else begin
            bal_d     = cur_bal - data_q;
            rsp_bal_d = bal_d;
          end
        end
        OP_DEPOSIT: begin
          if (sum17[16]) begin
            status_d = ST_OVERFLOW;
          end else begin
            bal_d     = sum17[15:0];
            rsp_bal_d = bal_d;
          end
        end
        OP_PIN_CHANGE: pin_d = data_q;
        OP_VERIFY, OP_BALANCE: ;
        default: ;
      endcase
    end
  end

  // Account storage: restored on reset, written only at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_q[i]   <= INIT_PIN;
        bal_q[i]   <= INIT_BALANCE;
        tries_q[i] <= '0;
      end
      locked_q <= '0;
    end else if (state_q == S_EXEC && wr_d) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        if (card_q == 8'(i)) begin
          pin_q[i]    <= pin_d;
          bal_q[i]    <= bal_d;
          tries_q[i]  <= tries_d;
          locked_q[i] <= lock_d;
        end
      end
    end
  end

  // Response registers load with the commit and hold through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_status_q <= 8'h00;
      rsp_bal_q    <= 16'h0000;
    end else if (state_q == S_EXEC) begin
      rsp_status_q <= status_d;
      rsp_bal_q    <= rsp_bal_d;
    end
  end

endmodule

// File: tb/tb_atm_account_server.sv
// Directed bench for atm_account_server with hand-computed expectations.
module tb_atm_account_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_card;
  logic [15:0] req_pin;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_status;
  logic [15:0] rsp_balance;
  logic [3:0]  locked;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  atm_account_server dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_card   (req_card),
    .req_pin    (req_pin),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_balance(rsp_balance),
    .locked     (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting just after a rising edge in IDLE.
  // hold = extra cycles the response is left waiting with rsp_ready low.
  task automatic xact(input logic [2:0] op, input logic [7:0] card,
                      input logic [15:0] pin, input logic [15:0] data,
                      input logic [7:0] exp_st, input logic [15:0] exp_bal,
                      input logic [3:0] exp_lock, input int hold, input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_op = op; req_card = card; req_pin = pin; req_data = data;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_pin = 16'hDEAD; req_data = 16'hBEEF;
    chk({tag, ".exec_vld"}, 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".status"},    32'(rsp_status), 32'(exp_st));
    chk({tag, ".balance"},   32'(rsp_balance), 32'(exp_bal));
    chk({tag, ".locked"},    32'(locked), 32'(exp_lock));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_st"},  32'(rsp_status), 32'(exp_st));
      chk({tag, ".hold_bal"}, 32'(rsp_balance), 32'(exp_bal));
      chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".done_vld"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_card = '0; req_pin = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.status",    32'(rsp_status), 32'd0);
    chk("rst.balance",   32'(rsp_balance), 32'd0);
    chk("rst.locked",    32'(locked), 32'd0);
    rst = 1'b0;

    // Balance and withdraw boundaries on card 0
    xact(3'd1, 8'd0, 16'h1234, 16'h0000, 8'h00, 16'h0500, 4'b0000, 0, "bal0");
    xact(3'd2, 8'd0, 16'h1234, 16'h0050, 8'h00, 16'h04B0, 4'b0000, 0, "wd50");
    xact(3'd2, 8'd0, 16'h1234, 16'h04B1, 8'h04, 16'h04B0, 4'b0000, 0, "wd_over");
    xact(3'd2, 8'd0, 16'h1234, 16'h04B0, 8'h00, 16'h0000, 4'b0000, 0, "wd_all");

    // Card 1: counter clears on a good PIN, then locks after three straight misses
    xact(3'd0, 8'd1, 16'h0000, 16'h0000, 8'h02, 16'h0000, 4'b0000, 0, "c1_bad1");
    xact(3'd0, 8'd1, 16'h0000, 16'h0000, 8'h02, 16'h0000, 4'b0000, 0, "c1_bad2");
    xact(3'd0, 8'd1, 16'h1234, 16'h0000, 8'h00, 16'h0500, 4'b0000, 0, "c1_good");
    xact(3'd0, 8'd1, 16'h0000, 16'h0000, 8'h02, 16'h0000, 4'b0000, 0, "c1_bad3");
    xact(3'd0, 8'd1, 16'h0000, 16'h0000, 8'h02, 16'h0000, 4'b0000, 0, "c1_bad4");
    xact(3'd0, 8'd1, 16'h0000, 16'h0000, 8'h02, 16'h0000, 4'b0010, 0, "c1_lock");
    xact(3'd1, 8'd1, 16'h1234, 16'h0000, 8'h03, 16'h0000, 4'b0010, 0, "c1_locked");
    xact(3'd1, 8'd2, 16'h1234, 16'h0000, 8'h00, 16'h0500, 4'b0010, 0, "c2_indep");

    // Deposit boundaries, bad card, illegal op, precedence of bad card
    xact(3'd3, 8'd3, 16'h1234, 16'hFAFF, 8'h00, 16'hFFFF, 4'b0010, 0, "dep_max");
    xact(3'd3, 8'd3, 16'h1234, 16'h0001, 8'h05, 16'hFFFF, 4'b0010, 0, "dep_ovf");
    xact(3'd1, 8'd4, 16'h1234, 16'h0000, 8'h01, 16'h0000, 4'b0010, 0, "bad_card");
    xact(3'd6, 8'd0, 16'h1234, 16'h0000, 8'h06, 16'h0000, 4'b0010, 0, "bad_op");
    xact(3'd7, 8'd5, 16'h0000, 16'h0000, 8'h01, 16'h0000, 4'b0010, 0, "card_first");
    xact(3'd6, 8'd1, 16'h1234, 16'h0000, 8'h06, 16'h0000, 4'b0010, 0, "op_b4_lock");

    // PIN change takes effect on the next request; response held 5 cycles
    xact(3'd4, 8'd2, 16'h1234, 16'h4321, 8'h00, 16'h0500, 4'b0010, 0, "pinchg");
    xact(3'd1, 8'd2, 16'h1234, 16'h0000, 8'h02, 16'h0000, 4'b0010, 0, "old_pin");
    xact(3'd1, 8'd2, 16'h4321, 16'h0000, 8'h00, 16'h0500, 4'b0010, 5, "new_pin");

    // Reset while in EXEC: nothing commits, storage returns to initial values
    req_op = 3'd2; req_card = 8'd3; req_pin = 16'h1234; req_data = 16'h0100;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid.req_ready", 32'(req_ready), 32'd1);
    chk("mid.status",    32'(rsp_status), 32'd0);
    chk("mid.balance",   32'(rsp_balance), 32'd0);
    chk("mid.locked",    32'(locked), 32'd0);
    xact(3'd1, 8'd3, 16'h1234, 16'h0000, 8'h00, 16'h0500, 4'b0000, 0, "rst_c3");
    xact(3'd1, 8'd0, 16'h1234, 16'h0000, 8'h00, 16'h0500, 4'b0000, 0, "rst_c0");
    xact(3'd1, 8'd2, 16'h1234, 16'h0000, 8'h00, 16'h0500, 4'b0000, 0, "rst_c2");
    xact(3'd1, 8'd1, 16'h1234, 16'h0000, 8'h00, 16'h0500, 4'b0000, 0, "rst_c1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
